change_dispense_seq: RTL and testbench

CHANGE_DISPENSE_SEQ -- requirements
Module: change_dispense_seq

---
 rtl/vend_pkg.sv | 35 +++
 rtl/dispense_ack_timer.sv | 38 +++
 rtl/change_dispense_seq.sv | 152 +++++++++++++++
 tb/tb_change_dispense_seq.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/vend_pkg.sv
// Shared types and constants for the change dispenser: FSM states, coin_sel
// encodings and the coin values they stand for.
package vend_pkg;

   localparam int DENOM_W = 8;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SELECT,
      ST_REQ,
      ST_ACK_LOW,
      ST_DONE,
      ST_FAULT
   } state_t;

   localparam logic [1:0] SEL_10 = 2'b00;
   localparam logic [1:0] SEL_5  = 2'b01;
   localparam logic [1:0] SEL_1  = 2'b10;

   localparam logic [DENOM_W-1:0] DENOM_10 = 8'd10;
   localparam logic [DENOM_W-1:0] DENOM_5  = 8'd5;
   localparam logic [DENOM_W-1:0] DENOM_1  = 8'd1;

   function automatic logic [DENOM_W-1:0] denom_of(input logic [1:0] sel);
      logic [DENOM_W-1:0] val;
      case (sel)
         SEL_10:  val = DENOM_10;
         SEL_5:   val = DENOM_5;
         SEL_1:   val = DENOM_1;
         default: val = '0;
      endcase
      return val;
   endfunction

endpackage

// File: rtl/dispense_ack_timer.sv
// Counts cycles spent waiting for a hopper acknowledge; expired_o is high on
// the LIMIT-th consecutive enabled cycle after a clear.
module dispense_ack_timer #(
   parameter int unsigned LIMIT = 200
) (
   input  logic clk,
   input  logic rst,
   input  logic clear_i,
   input  logic enable_i,
   output logic expired_o
);

   localparam int CNT_W = (LIMIT < 2) ? 1 : $clog2(LIMIT + 1);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(LIMIT - 1);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   assign expired_o = (cnt_q >= LAST);

   always_comb begin
      cnt_d = cnt_q;
      if (clear_i) begin
         cnt_d = '0;
      end else if (enable_i && !expired_o) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/change_dispense_seq.sv
// Change dispenser: pays out change_amt greedily in 10/5/1 coins through a
// four-phase coin_req/hopper_ack handshake, tracking per-coin inventories.
module change_dispense_seq
   import vend_pkg::*;
#(
   parameter int unsigned INV_INIT    = 20,
   parameter int unsigned ACK_TIMEOUT = 200
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic [DENOM_W-1:0] change_amt,
   input  logic               refill,
   input  logic               fault_clr,
   input  logic               hopper_ack,
   output logic               coin_req,
   output logic [1:0]         coin_sel,
   output logic               busy,
   output logic               done,
   output logic               short_alarm,
   output logic [DENOM_W-1:0] remaining,
   output logic [DENOM_W-1:0] inv10,
   output logic [DENOM_W-1:0] inv5,
   output logic [DENOM_W-1:0] inv1
);

   localparam logic [DENOM_W-1:0] INV_LOAD = DENOM_W'(INV_INIT);

   state_t             state_q, state_d;
   logic [DENOM_W-1:0] rem_q, rem_d;
   logic [1:0]         sel_q, sel_d;
   logic [DENOM_W-1:0] inv10_q, inv10_d;
   logic [DENOM_W-1:0] inv5_q, inv5_d;
   logic [DENOM_W-1:0] inv1_q, inv1_d;
   logic               ack_expired;

   dispense_ack_timer #(
      .LIMIT (ACK_TIMEOUT)
   ) u_ack_timer (
      .clk       (clk),
      .rst       (rst),
      .clear_i   (state_q != ST_REQ),
      .enable_i  (state_q == ST_REQ),
      .expired_o (ack_expired)
   );

   always_comb begin
      state_d = state_q;
      rem_d   = rem_q;
      sel_d   = sel_q;
      inv10_d = inv10_q;
      inv5_d  = inv5_q;
      inv1_d  = inv1_q;

      case (state_q)
         ST_IDLE: begin
            // A refill in the same cycle wins and swallows the start.
            if (refill) begin
               inv10_d = INV_LOAD;
               inv5_d  = INV_LOAD;
               inv1_d  = INV_LOAD;
            end else if (start) begin
               rem_d   = change_amt;
               state_d = (change_amt == '0) ? ST_DONE : ST_SELECT;
            end
         end
         ST_SELECT: begin
            if (rem_q == '0) begin
               state_d = ST_DONE;
            end else if (rem_q >= DENOM_10 && inv10_q != '0) begin
               sel_d   = SEL_10;
               state_d = ST_REQ;
            end else if (rem_q >= DENOM_5 && inv5_q != '0) begin
               sel_d   = SEL_5;
               state_d = ST_REQ;
            end else if (inv1_q != '0) begin
               sel_d   = SEL_1;
               state_d = ST_REQ;
            end else begin
               state_d = ST_FAULT;
            end
         end
         ST_REQ: begin
            // An acknowledge on the final timeout cycle still counts as delivered.
            if (hopper_ack) begin
               rem_d = rem_q - denom_of(sel_q);
               case (sel_q)
                  SEL_10:  inv10_d = inv10_q - 1'b1;
                  SEL_5:   inv5_d  = inv5_q - 1'b1;
                  SEL_1:   inv1_d  = inv1_q - 1'b1;
                  default: ;
               endcase
               state_d = ST_ACK_LOW;
            end else if (ack_expired) begin
               state_d = ST_FAULT;
            end
         end
         ST_ACK_LOW: begin
            if (!hopper_ack) begin
               state_d = ST_SELECT;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         ST_FAULT: begin
            if (refill) begin
               inv10_d = INV_LOAD;
               inv5_d  = INV_LOAD;
               inv1_d  = INV_LOAD;
            end
            if (fault_clr) begin
               rem_d   = '0;
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         rem_q   <= '0;
         sel_q   <= SEL_10;
         inv10_q <= INV_LOAD;
         inv5_q  <= INV_LOAD;
         inv1_q  <= INV_LOAD;
      end else begin
         state_q <= state_d;
         rem_q   <= rem_d;
         sel_q   <= sel_d;
         inv10_q <= inv10_d;
         inv5_q  <= inv5_d;
         inv1_q  <= inv1_d;
      end
   end

   // Status outputs are pure decodes of the state register.
   assign coin_req    = (state_q == ST_REQ);
   assign coin_sel    = sel_q;
   assign busy        = (state_q != ST_IDLE);
   assign done        = (state_q == ST_DONE);
   assign short_alarm = (state_q == ST_FAULT);
   assign remaining   = rem_q;
   assign inv10       = inv10_q;
   assign inv5        = inv5_q;
   assign inv1        = inv1_q;

endmodule

// File: tb/tb_change_dispense_seq.sv
// Bench for change_dispense_seq: a hopper model checks each requested coin
// against a queue of expected coin_sel values pushed when a start is driven.
module tb_change_dispense_seq;

   logic       clk;
   logic       rst;
   logic       start_a, start_b;
   logic [7:0] change_amt;
   logic       refill_a, refill_b;
   logic       fault_clr;
   logic       hopper_ack;

   logic       coin_req_a, busy_a, done_a, short_alarm_a;
   logic [1:0] coin_sel_a;
   logic [7:0] remaining_a, inv10_a, inv5_a, inv1_a;
   logic       coin_req_b, busy_b, done_b, short_alarm_b;
   logic [1:0] coin_sel_b;
   logic [7:0] remaining_b, inv10_b, inv5_b, inv1_b;

   int         n_cmp = 0;
   int         n_bad = 0;
   logic [1:0] exp_q[$];
   bit         hopper_en;
   bit         use_b;
   int         ack_delay;
   int         req_cycles_a;

   logic       coin_req_m;
   logic [1:0] coin_sel_m;
   assign coin_req_m = use_b ? coin_req_b : coin_req_a;
   assign coin_sel_m = use_b ? coin_sel_b : coin_sel_a;

   change_dispense_seq u_dut_a (
      .clk(clk), .rst(rst), .start(start_a), .change_amt(change_amt),
      .refill(refill_a), .fault_clr(fault_clr), .hopper_ack(hopper_ack),
      .coin_req(coin_req_a), .coin_sel(coin_sel_a), .busy(busy_a), .done(done_a),
      .short_alarm(short_alarm_a), .remaining(remaining_a),
      .inv10(inv10_a), .inv5(inv5_a), .inv1(inv1_a)
   );

   change_dispense_seq #(.INV_INIT(1)) u_dut_b (
      .clk(clk), .rst(rst), .start(start_b), .change_amt(change_amt),
      .refill(refill_b), .fault_clr(fault_clr), .hopper_ack(hopper_ack),
      .coin_req(coin_req_b), .coin_sel(coin_sel_b), .busy(busy_b), .done(done_b),
      .short_alarm(short_alarm_b), .remaining(remaining_b),
      .inv10(inv10_b), .inv5(inv5_b), .inv1(inv1_b)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   always @(negedge clk) if (coin_req_a) req_cycles_a++;

   // Hopper model: pops the expected coin on each new request, acks after
   // ack_delay cycles and releases ack once coin_req drops.
   initial begin
      hopper_ack = 1'b0;
      forever begin
         @(negedge clk);
         if (hopper_en && coin_req_m && !hopper_ack) begin
            if (exp_q.size() == 0) check("coin_unexpected", 32'd1, 32'd0);
            else                   check("coin_sel", {30'd0, coin_sel_m}, {30'd0, exp_q.pop_front()});
            repeat (ack_delay) @(negedge clk);
            hopper_ack = 1'b1;
            for (int i = 0; i < 20; i++) begin
               @(negedge clk);
               if (!coin_req_m) break;
            end
            check("req_drop_on_ack", {31'd0, coin_req_m}, 32'd0);
            hopper_ack = 1'b0;
         end
      end
   end

   task automatic wait_done_a(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 400; i++) begin
         if (done_a) begin
            ok = 1'b1;
            break;
         end
         @(negedge clk);
      end
   endtask

   task automatic pulse_start_a(input logic [7:0] amt);
      change_amt = amt;
      start_a    = 1'b1;
      @(negedge clk);
      start_a    = 1'b0;
   endtask

   initial begin
      bit ok;
      int n;
      rst = 1'b1; start_a = 1'b0; start_b = 1'b0; change_amt = '0;
      refill_a = 1'b0; refill_b = 1'b0; fault_clr = 1'b0;
      hopper_en = 1'b0; use_b = 1'b0; ack_delay = 2;

      // Reset state
      repeat (3) @(negedge clk);
      check("rst_coin_req", {31'd0, coin_req_a}, 0);
      check("rst_coin_sel", {30'd0, coin_sel_a}, 0);
      check("rst_busy", {31'd0, busy_a}, 0);
      check("rst_done", {31'd0, done_a}, 0);
      check("rst_alarm", {31'd0, short_alarm_a}, 0);
      check("rst_remaining", {24'd0, remaining_a}, 0);
      check("rst_inv10", {24'd0, inv10_a}, 20);
      check("rst_inv5", {24'd0, inv5_a}, 20);
      check("rst_inv1", {24'd0, inv1_a}, 20);
      check("rst_inv10_b", {24'd0, inv10_b}, 1);
      rst = 1'b0;
      @(negedge clk);

      // 27 units -> 10,10,5,1,1
      exp_q.push_back(2'b00); exp_q.push_back(2'b00); exp_q.push_back(2'b01);
      exp_q.push_back(2'b10); exp_q.push_back(2'b10);
      hopper_en = 1'b1;
      pulse_start_a(8'd27);
      wait_done_a(ok);
      check("t27_done_seen", {31'd0, ok}, 1);
      check("t27_remaining", {24'd0, remaining_a}, 0);
      check("t27_inv10", {24'd0, inv10_a}, 18);
      check("t27_inv5", {24'd0, inv5_a}, 19);
      check("t27_inv1", {24'd0, inv1_a}, 18);
      @(negedge clk);
      check("t27_done_width", {31'd0, done_a}, 0);
      check("t27_idle", {31'd0, busy_a}, 0);
      check("t27_queue_empty", exp_q.size(), 0);

      // Zero change: done one cycle after start, no coin requested
      req_cycles_a = 0;
      pulse_start_a(8'd0);
      check("z_done", {31'd0, done_a}, 1);
      check("z_busy", {31'd0, busy_a}, 1);
      @(negedge clk);
      check("z_done_width", {31'd0, done_a}, 0);
      check("z_idle", {31'd0, busy_a}, 0);
      repeat (3) @(negedge clk);
      check("z_no_coin_req", req_cycles_a, 0);

      // Acknowledge never arrives -> FAULT after exactly 200 REQ cycles
      hopper_en = 1'b0;
      pulse_start_a(8'd12);
      ok = 1'b0;
      for (int i = 0; i < 10; i++) begin
         if (coin_req_a) begin ok = 1'b1; break; end
         @(negedge clk);
      end
      check("to_req_seen", {31'd0, ok}, 1);
      n = 0;
      for (int i = 0; i < 400; i++) begin
         if (!coin_req_a) break;
         n++;
         @(negedge clk);
      end
      check("to_req_cycles", n, 200);
      check("to_alarm", {31'd0, short_alarm_a}, 1);
      check("to_remaining", {24'd0, remaining_a}, 12);
      check("to_inv10", {24'd0, inv10_a}, 18);
      check("to_inv5", {24'd0, inv5_a}, 19);
      check("to_inv1", {24'd0, inv1_a}, 18);
      refill_a = 1'b1;
      @(negedge clk);
      refill_a = 1'b0;
      check("fault_refill_stays", {31'd0, short_alarm_a}, 1);
      check("fault_refill_inv10", {24'd0, inv10_a}, 20);
      check("fault_refill_inv1", {24'd0, inv1_a}, 20);
      fault_clr = 1'b1;
      @(negedge clk);
      fault_clr = 1'b0;
      check("clr_idle", {31'd0, busy_a}, 0);
      check("clr_remaining", {24'd0, remaining_a}, 0);
      check("clr_alarm", {31'd0, short_alarm_a}, 0);

      // start and refill while busy are ignored
      hopper_en = 1'b1; ack_delay = 4;
      exp_q.push_back(2'b00); exp_q.push_back(2'b01);
      pulse_start_a(8'd15);
      check("b_busy", {31'd0, busy_a}, 1);
      change_amt = 8'd99; start_a = 1'b1; refill_a = 1'b1;
      @(negedge clk);
      start_a = 1'b0; refill_a = 1'b0;
      wait_done_a(ok);
      check("b_done_seen", {31'd0, ok}, 1);
      check("b_inv10", {24'd0, inv10_a}, 19);
      check("b_inv5", {24'd0, inv5_a}, 19);
      check("b_inv1", {24'd0, inv1_a}, 20);
      @(negedge clk);
      check("b_queue_empty", exp_q.size(), 0);

      // refill + start together in IDLE: refill only
      req_cycles_a = 0;
      change_amt = 8'd5; start_a = 1'b1; refill_a = 1'b1;
      @(negedge clk);
      start_a = 1'b0; refill_a = 1'b0;
      check("rs_idle", {31'd0, busy_a}, 0);
      check("rs_inv10", {24'd0, inv10_a}, 20);
      check("rs_inv5", {24'd0, inv5_a}, 20);
      repeat (4) @(negedge clk);
      check("rs_no_txn", {31'd0, busy_a}, 0);
      check("rs_no_coin_req", req_cycles_a, 0);

      // Reset during the second coin request of a 15-unit payout
      ack_delay = 3;
      exp_q.push_back(2'b00); exp_q.push_back(2'b01);
      pulse_start_a(8'd15);
      ok = 1'b0;
      for (int i = 0; i < 60; i++) begin
         if (coin_req_a && inv10_a == 8'd19) begin ok = 1'b1; break; end
         @(negedge clk);
      end
      check("mr_second_req", {31'd0, ok}, 1);
      rst = 1'b1;
      #1;
      check("mr_coin_req", {31'd0, coin_req_a}, 0);
      check("mr_idle", {31'd0, busy_a}, 0);
      check("mr_remaining", {24'd0, remaining_a}, 0);
      check("mr_inv10", {24'd0, inv10_a}, 20);
      check("mr_inv5", {24'd0, inv5_a}, 20);
      hopper_en = 1'b0;
      repeat (6) @(negedge clk);
      rst = 1'b0;
      exp_q.delete();
      req_cycles_a = 0;
      repeat (4) @(negedge clk);
      check("mr_stays_idle", {31'd0, busy_a}, 0);
      check("mr_no_coin_req", req_cycles_a, 0);

      // INV_INIT=1: 23 runs out after 10,5,1 with 7 owed
      use_b = 1'b1; hopper_en = 1'b1; ack_delay = 2;
      exp_q.push_back(2'b00); exp_q.push_back(2'b01); exp_q.push_back(2'b10);
      change_amt = 8'd23; start_b = 1'b1;
      @(negedge clk);
      start_b = 1'b0;
      ok = 1'b0;
      for (int i = 0; i < 300; i++) begin
         if (short_alarm_b) begin ok = 1'b1; break; end
         @(negedge clk);
      end
      check("sh_fault_seen", {31'd0, ok}, 1);
      check("sh_remaining", {24'd0, remaining_b}, 7);
      check("sh_inv10", {24'd0, inv10_b}, 0);
      check("sh_inv5", {24'd0, inv5_b}, 0);
      check("sh_inv1", {24'd0, inv1_b}, 0);
      check("sh_coin_req", {31'd0, coin_req_b}, 0);
      check("sh_queue_empty", exp_q.size(), 0);
      fault_clr = 1'b1;
      @(negedge clk);
      fault_clr = 1'b0;
      check("sh_clr_idle", {31'd0, busy_b}, 0);
      check("sh_clr_remaining", {24'd0, remaining_b}, 0);
      check("sh_clr_alarm", {31'd0, short_alarm_b}, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
